// File: rtl/trace_uart_bridge.sv
// trace_uart_bridge: buffers the trace byte stream in a FIFO and feeds it to
// the UART transmitter. Lost bytes are reported in-band as a MARKER/count
// pair, and data bytes equal to MARKER are escaped as MARKER/00.
//
// Handshake: a byte is offered to the UART by a one-cycle tx_strobe with
// tx_byte already valid; the UART acknowledges by raising tx_busy and signals
// completion by dropping it. tx_byte is held until the next strobe.
module trace_uart_bridge #(
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter int         HIWATER = 12,
    parameter logic [7:0] MARKER  = 8'hA5
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    input  logic          tx_busy,
    output logic          tx_strobe,
    output logic [7:0]    tx_byte,
    output logic [AW:0]   fill,
    output logic          cts,
    output logic          ovf,
    output logic          drops_pending
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] HI_LVL   = (AW + 1)'(HIWATER);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, ACK, DONE, SECOND} state_t;
    state_t state, nextState;

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wrPtr, rdPtr, occ, occNext;
    logic        full, empty, slotFree, doWrite, doPop;
    logic [8:0]  wrData, head;
    logic [7:0]  dropCnt, dropCntInc, dropCntNow;
    logic        secondPending;
    logic [7:0]  secondByte;
    logic        loadFirst, loadSecond;

    assign occ        = wrPtr - rdPtr;
    assign full       = (occ == FULL_LVL);
    assign empty      = (occ == '0);
    assign head       = mem[rdPtr[AW-1:0]];
    assign slotFree   = !full || doPop;
    assign dropCntInc = (dropCnt == 8'hFF) ? 8'hFF : dropCnt + 8'd1;
    // Count as it stands this cycle, including a byte lost right now.
    assign dropCntNow = in_valid ? dropCntInc : dropCnt;
    assign occNext    = occ + {{AW{1'b0}}, doWrite} - {{AW{1'b0}}, doPop};

    // Write selection: a pending drop record always goes in before new data.
    always_comb begin
        doWrite = 1'b0;
        wrData  = {1'b0, in_byte};
        if (drops_pending) begin
            if (slotFree) begin
                doWrite = 1'b1;
                wrData  = {1'b1, dropCntNow};
            end
        end else if (in_valid && slotFree) begin
            doWrite = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

    // Pointers plus registered occupancy and flow-control status.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            fill  <= '0;
            cts   <= 1'b1;
        end else begin
            if (doWrite) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)   rdPtr <= rdPtr + PTR_ONE;
            fill <= occNext;
            cts  <= (occNext < HI_LVL);
        end
    end

    // Drop accounting: count lost bytes until a slot frees for the record.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            dropCnt       <= '0;
            drops_pending <= 1'b0;
            ovf           <= 1'b0;
        end else if (drops_pending) begin
            if (slotFree) begin
                dropCnt       <= '0;
                drops_pending <= 1'b0;
            end else if (in_valid) begin
                dropCnt <= dropCntInc;
            end
        end else if (in_valid && !slotFree) begin
            dropCnt       <= 8'd1;
            drops_pending <= 1'b1;
            ovf           <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= nextState;
    end

    // FSM next-state logic; pops happen only from IDLE so pairs stay together.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!empty && !tx_busy) nextState = ACK;
            ACK:     if (tx_busy) nextState = DONE;
            DONE:    if (!tx_busy) nextState = secondPending ? SECOND : IDLE;
            SECOND:  nextState = ACK;
            default: nextState = IDLE;
        endcase
    end

    // FSM output decode: which byte (first or second) is loaded this cycle.
    always_comb begin
        loadFirst  = (state == IDLE) && !empty && !tx_busy;
        loadSecond = (state == SECOND);
        doPop      = loadFirst;
    end

    // Transmit register: strobe follows a load by one cycle, byte held after.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx_strobe     <= 1'b0;
            tx_byte       <= '0;
            secondPending <= 1'b0;
            secondByte    <= '0;
        end else begin
            tx_strobe <= loadFirst || loadSecond;
            if (loadFirst) begin
                if (head[8]) begin
                    tx_byte       <= MARKER;
                    secondByte    <= head[7:0];
                    secondPending <= 1'b1;
                end else if (head[7:0] == MARKER) begin
                    tx_byte       <= MARKER;
                    secondByte    <= 8'h00;
                    secondPending <= 1'b1;
                end else begin
                    tx_byte       <= head[7:0];
                    secondPending <= 1'b0;
                end
            end else if (loadSecond) begin
                tx_byte       <= secondByte;
                secondPending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_uart_bridge.sv
// Directed testbench for trace_uart_bridge with a simple UART busy model.
module tb_trace_uart_bridge;

    logic       clk = 1'b0;
    logic       nRst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       tx_busy;
    logic       tx_strobe;
    logic [7:0] tx_byte;
    logic [4:0] fill;
    logic       cts;
    logic       ovf;
    logic       drops_pending;

    logic       holdBusy;
    int         busyCnt = 0;
    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];
    int         checks = 0;
    int         errors = 0;

    trace_uart_bridge #(
        .DEPTH(16), .AW(4), .HIWATER(12), .MARKER(8'hA5)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .tx_busy(tx_busy),
        .tx_strobe(tx_strobe),
        .tx_byte(tx_byte),
        .fill(fill),
        .cts(cts),
        .ovf(ovf),
        .drops_pending(drops_pending)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles after each accepted strobe.
    assign tx_busy = holdBusy || (busyCnt != 0);

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            busyCnt <= 0;
        end else if (tx_strobe) begin
            rxQ.push_back(tx_byte);
            busyCnt <= 10;
        end else if (busyCnt != 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic compareStreams(input string tag);
        check({tag, "_count"}, rxQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), rxQ[i], expQ[i]);
        end
        rxQ.delete();
        expQ.delete();
    endtask

    task automatic drain(input string tag, input int n);
        int cyc;
        cyc = 0;
        while (rxQ.size() < n && cyc < 2000) begin
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, (cyc < 2000), 1);
        repeat (20) tick();
        compareStreams(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRst     = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        holdBusy = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_fill", fill, 0);
        check("rst_cts", cts, 1);
        check("rst_ovf", ovf, 0);
        check("rst_dp", drops_pending, 0);
        check("rst_strobe", tx_strobe, 0);
        check("rst_byte", tx_byte, 0);
        nRst = 1'b1;
        tick();

        // Single byte: strobe two cycles after in_valid
        sendByte(8'h3C);
        check("t1_fill1", fill, 1);
        check("t1_nostrobe", tx_strobe, 0);
        tick();
        check("t1_strobe", tx_strobe, 1);
        check("t1_byte", tx_byte, 8'h3C);
        check("t1_fill0", fill, 0);
        tick();
        check("t1_strobe_off", tx_strobe, 0);
        check("t1_byte_hold", tx_byte, 8'h3C);
        expQ.push_back(8'h3C);
        drain("t1", 1);

        // Marker-valued data is escaped as A5,00
        sendByte(8'hA5);
        expQ.push_back(8'hA5);
        expQ.push_back(8'h00);
        drain("t2", 2);
        check("t2_ovf", ovf, 0);

        // Overflow: 20 bytes into 16 entries with UART held busy
        holdBusy = 1'b1;
        for (int i = 0; i < 16; i++) sendByte(8'(i));
        check("t3_fill_full", fill, 16);
        check("t3_cts_full", cts, 0);
        check("t3_ovf_pre", ovf, 0);
        check("t3_dp_pre", drops_pending, 0);
        sendByte(8'd16);
        check("t3_ovf", ovf, 1);
        check("t3_dp", drops_pending, 1);
        check("t3_fill_hold", fill, 16);
        for (int i = 17; i < 20; i++) sendByte(8'(i));
        holdBusy = 1'b0;
        tick();
        check("t3_dp_clear", drops_pending, 0);
        check("t3_fill_rw", fill, 16);
        check("t3_ovf_sticky", ovf, 1);
        repeat (20) tick();
        sendByte(8'h77);
        for (int i = 0; i < 16; i++) expQ.push_back(8'(i));
        expQ.push_back(8'hA5);
        expQ.push_back(8'h04);
        expQ.push_back(8'h77);
        drain("t3", 19);

        // Saturating drop count: 300 bytes lost
        holdBusy = 1'b1;
        for (int i = 0; i < 16; i++) sendByte(8'h40 + 8'(i));
        for (int i = 0; i < 300; i++) sendByte(8'hEE);
        check("t4_dp", drops_pending, 1);
        check("t4_fill", fill, 16);
        holdBusy = 1'b0;
        tick();
        check("t4_dp_clear", drops_pending, 0);
        repeat (20) tick();
        sendByte(8'h99);
        for (int i = 0; i < 16; i++) expQ.push_back(8'h40 + 8'(i));
        expQ.push_back(8'hA5);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h99);
        drain("t4", 19);

        // High-water flow control and read/write at full
        holdBusy = 1'b1;
        for (int i = 0; i < 11; i++) sendByte(8'h10 + 8'(i));
        check("t5_fill11", fill, 11);
        check("t5_cts11", cts, 1);
        sendByte(8'h1B);
        check("t5_fill12", fill, 12);
        check("t5_cts12", cts, 0);
        holdBusy = 1'b0;
        tick();
        check("t5_fill_pop", fill, 11);
        check("t5_cts_pop", cts, 1);
        holdBusy = 1'b1;
        for (int i = 0; i < 5; i++) sendByte(8'h1C + 8'(i));
        check("t5_fill16", fill, 16);
        repeat (12) tick();
        holdBusy = 1'b0;
        tick();
        sendByte(8'h21);
        check("t5_fill_rw", fill, 16);
        check("t5_dp_rw", drops_pending, 0);
        for (int i = 0; i < 18; i++) expQ.push_back(8'h10 + 8'(i));
        drain("t5", 18);

        // Reset during ACK of a marker pair
        sendByte(8'hA5);
        tick();
        check("t6_strobe_pre", tx_strobe, 1);
        nRst = 1'b0;
        #1;
        check("t6_strobe", tx_strobe, 0);
        check("t6_byte", tx_byte, 0);
        check("t6_fill", fill, 0);
        check("t6_cts", cts, 1);
        check("t6_ovf", ovf, 0);
        check("t6_dp", drops_pending, 0);
        repeat (2) tick();
        nRst = 1'b1;
        tick();
        sendByte(8'h5A);
        expQ.push_back(8'h5A);
        drain("t6", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_uart_bridge.md
Name: trace_uart_bridge

Overview:
- Buffered bridge between the trace byte stream (dvalid/dOut from the trace front end) and the UART transmitter; it replaces the direct unbuffered connection between the two.
- A parametric FIFO absorbs trace bursts. Overflow is detected and reported in-band as a marker/count pair, so the host can see exactly where and how many bytes were lost.
- Data bytes equal to the marker value are escaped, which keeps the output stream unambiguous.
- Also provides fill-level, high-water flow-control and overflow status outputs.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- AW, 4, log2(DEPTH).
- HIWATER, 12, fill level at which cts deasserts; must satisfy 1 <= HIWATER <= DEPTH.
- MARKER, 8'hA5, in-band escape/overflow marker byte.

Ports:
- clk  in  1  system clock (48 MHz)
- nRst  in  1  asynchronous active-low reset
- in_valid  in  1  trace byte strobe, one cycle per byte
- in_byte  in  8  trace byte
- tx_busy  in  1  UART transmitter busy (is_transmitting)
- tx_strobe  out  1  one-cycle transmit request to UART
- tx_byte  out  8  byte to transmit; stable from the tx_strobe cycle until tx_busy falls
- fill  out  AW+1  current FIFO occupancy, 0..DEPTH
- cts  out  1  high while fill < HIWATER
- ovf  out  1  sticky overflow flag; cleared only by reset
- drops_pending  out  1  lost bytes not yet recorded in FIFO

Behaviour:
- Reset (async, nRst low) values:
  - FIFO empty, fill=0, cts=1, ovf=0, drops_pending=0.
  - tx_strobe=0, tx_byte=0, drop counter=0, FSM=IDLE.
  - Reset mid-transfer abandons the current byte; there is no recovery of FIFO contents.
- FIFO format:
  - 9-bit entries: bit8=0 is a data byte; bit8=1 is a drop record whose bits7:0 hold the count.
  - Read/write pointers are AW+1 bits; wrap-around is natural binary rollover.
- Write side, evaluated each cycle:
  - drops_pending=0, in_valid=1, FIFO not full (or a read occurs this same cycle): write {0,in_byte}.
  - drops_pending=0, in_valid=1, FIFO full with no read this cycle: the byte is lost. Set drop counter=1, drops_pending=1, ovf=1.
  - drops_pending=1, in_valid=1: the byte is always lost. Increment the counter, saturating at 255; the incoming byte is included in the count.
  - drops_pending=1 and a slot is free (not full, or a read this cycle): write {1,count} that same cycle. Here count includes any in_valid byte lost in this cycle. Then clear the counter and drops_pending.
  - Consequence: no data byte is ever written ahead of a pending drop record, so stream order is preserved.
- Simultaneous read and write: a read and a write in the same cycle leave fill unchanged; a full FIFO accepts a write in a read cycle.
- fill and cts are registered from the post-update occupancy (one cycle after the pointer change).
- Read/transmit FSM:
  - IDLE:
    - Wait for FIFO non-empty and tx_busy=0, then pop the head entry.
    - Data byte != MARKER: tx_byte=data, pulse tx_strobe, go to ACK, with no second byte.
    - Data byte == MARKER: send MARKER, then second byte 8'h00.
    - Drop record: send MARKER, then second byte = count (1..255).
  - ACK: wait for tx_busy=1, then go to DONE. tx_strobe is high only in the cycle of the IDLE/SECOND transition.
  - DONE: wait for tx_busy=0.
    - If a second byte is pending, go to SECOND.
    - Otherwise go to IDLE.
  - SECOND: load the second byte into tx_byte, pulse tx_strobe, go to ACK with no second byte pending.
- Latency: a byte written into an empty FIFO with tx_busy=0 produces tx_strobe 2 cycles after in_valid (one cycle write, one cycle pop).
- The FSM never pops while in ACK, DONE or SECOND; a marker pair is therefore never split by other traffic.

Test Plan:
- Single byte 8'h3C into idle bridge, tx_busy model with 10-cycle busy after each strobe -> tx_strobe 2 cycles later with tx_byte=8'h3C; fill returns to 0.
- Byte 8'hA5 -> two UART frames 8'hA5, 8'h00 in order; ovf stays 0.
- DEPTH=16, UART held busy, 20 consecutive bytes 0..19, then UART released:
  - ovf=1 and drops_pending=1 after byte 16.
  - Output is 0..15, then a drop record emitted as 8'hA5 then a count of 4 or more. The count covers bytes 16..19 plus any later input arriving before the first slot frees.
  - Only data sent after the record is transmitted after it.
- 300 bytes dropped while FIFO full -> the drop record count saturates at 8'hFF; the next accepted byte follows the record.
- HIWATER=12: fill 11→12 deasserts cts the cycle after the write; popping back to 11 reasserts cts. Simultaneous in_valid and pop at full leaves fill=16 with no drop.
- Assert nRst low while the FSM is in ACK mid-marker-pair -> all outputs immediately take their reset values; after release, new input bytes are transmitted normally with no stale second byte.
